max_bound_accumulator: RTL and testbench

- Downstream stage of the first-layer pairwise max comparators in the constraint-bound path.
- Serially consumes a stream of per-pair maxima, each tagged with an activation bit, and reduces them to one running maximum (the variable's lower bound) over a fixed number of beats.
- Presents the final bound and a bound-valid flag to the proposal/sampling logic, with a start/done handshake.

---
 rtl/max_bound_accumulator_pkg.sv | 16 +
 rtl/max_bound_accumulator_step.sv | 22 ++
 rtl/max_bound_accumulator.sv | 107 ++++++++++
 tb/tb_max_bound_accumulator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/max_bound_accumulator_pkg.sv
// Shared types and constants for the constraint-bound max reduction path.
package max_bound_accumulator_pkg;

    // Bound width shared with the first-layer pairwise comparators.
    localparam int DEFAULT_WIDTH = 8;

    // Most-negative bound at the default width; identity element of max().
    localparam logic signed [DEFAULT_WIDTH-1:0] BOUND_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/max_bound_accumulator_step.sv
// One reduction step: fold an activated candidate into the running maximum.
// Kept combinational and stateless so a parallel tree variant can reuse it.
module bound_max_step #(
    parameter int WIDTH = max_bound_accumulator_pkg::DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] acc,
    input  logic                    act_seen,
    input  logic signed [WIDTH-1:0] value,
    input  logic                    activation,
    output logic signed [WIDTH-1:0] acc_nxt,
    output logic                    act_seen_nxt
);

    // Inactive beats pass through untouched; ties keep the current value.
    always_comb begin
        acc_nxt      = acc;
        act_seen_nxt = act_seen | activation;
        if (activation && (value > acc))
            acc_nxt = value;
    end

endmodule

// File: rtl/max_bound_accumulator.sv
// Serial max reduction of NUM_ITEMS tagged beats into a lower bound,
// with a start/done handshake toward the proposal/sampling logic.
module max_bound_accumulator
    import max_bound_accumulator_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_ITEMS = 4,
    parameter int CNT_W     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_value,
    input  logic                    in_activation,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] bound,
    output logic                    bound_valid
);

    localparam logic signed [WIDTH-1:0] ACC_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NUM_ITEMS - 1);

    state_t                    state, state_nxt;
    logic signed [WIDTH-1:0]   acc;
    logic                      act_seen;
    logic [CNT_W-1:0]          count;
    logic signed [WIDTH-1:0]   step_acc;
    logic                      step_act;
    logic                      accept;
    logic                      final_beat;

    assign accept     = in_valid && (state == ACCUM);
    assign final_beat = accept && (count == LAST_CNT);

    assign in_ready = (state == ACCUM);
    assign busy     = (state == ACCUM);
    assign done     = (state == DONE);

    bound_max_step #(.WIDTH(WIDTH)) u_step (
        .acc          (acc),
        .act_seen     (act_seen),
        .value        (in_value),
        .activation   (in_activation),
        .acc_nxt      (step_acc),
        .act_seen_nxt (step_act)
    );

    // Next-state: the final beat wins over a coincident start; start in ACCUM restarts in place.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (final_beat) state_nxt = DONE;
            DONE:    state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: running max, activation flag, beat counter and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= ACC_MIN;
            act_seen    <= 1'b0;
            count       <= '0;
            bound       <= ACC_MIN;
            bound_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (final_beat) begin
                        bound       <= step_acc;
                        bound_valid <= step_act;
                        acc         <= ACC_MIN;
                        act_seen    <= 1'b0;
                        count       <= '0;
                    end else if (start) begin
                        // Abort: any beat presented this cycle is dropped.
                        acc      <= ACC_MIN;
                        act_seen <= 1'b0;
                        count    <= '0;
                    end else if (accept) begin
                        acc      <= step_acc;
                        act_seen <= step_act;
                        count    <= count + CNT_W'(1);
                    end
                end
                default: begin
                    if (start) begin
                        acc      <= ACC_MIN;
                        act_seen <= 1'b0;
                        count    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_bound_accumulator.sv
// Self-checking bench: directed scenarios plus randomized runs against a max() model.
module tb_max_bound_accumulator;

    localparam int W = 8;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_value;
    logic                in_activation;
    logic                busy;
    logic                done;
    logic signed [W-1:0] bound;
    logic                bound_valid;

    int checks = 0;
    int errors = 0;

    // Model state: result expected to be held by the DUT.
    logic signed [W-1:0] exp_bound;
    logic                exp_bv;

    max_bound_accumulator #(.WIDTH(W), .NUM_ITEMS(N), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .in_activation (in_activation),
        .busy          (busy),
        .done          (done),
        .bound         (bound),
        .bound_valid   (bound_valid)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic a, input logic signed [W-1:0] v);
        in_valid      = 1'b1;
        in_activation = a;
        in_value      = v;
        step();
        in_valid      = 1'b0;
    endtask

    // Reference: maximum over activated values, starting from the most-negative value.
    function automatic logic signed [W-1:0] ref_max(input logic [N-1:0] acts,
                                                    input logic [N-1:0][W-1:0] vals);
        int m = -128;
        for (int i = 0; i < N; i++)
            if (acts[i] && $signed(vals[i]) > m) m = $signed(vals[i]);
        return W'(m);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_value = '0; in_activation = 1'b0;
        #12;
        checks++; if (bound !== -8'sd128) begin errors++; $display("FAIL reset_bound got %0d want -128", bound); end
        checks++; if ({bound_valid, busy, done, in_ready} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {bound_valid, busy, done, in_ready}); end
        rst_n = 1'b1;
        step();
        exp_bound = -8'sd128; exp_bv = 1'b0;
    endtask

    // Feed four beats back-to-back and check the completion cycle.
    task automatic run4(input string name, input logic [N-1:0] acts, input logic [N-1:0][W-1:0] vals);
        pulse_start();
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_busy got %b%b want 11", name, busy, in_ready); end
        for (int i = 0; i < N; i++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_early_done beat %0d got %b want 0", name, i, done); end
            beat(acts[i], $signed(vals[i]));
        end
        exp_bound = ref_max(acts, vals); exp_bv = |acts;
        checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL %s_done got %b/%b want 1/0", name, done, in_ready); end
        checks++; if (bound !== exp_bound) begin errors++; $display("FAIL %s_bound got %0d want %0d", name, bound, exp_bound); end
        checks++; if (bound_valid !== exp_bv) begin errors++; $display("FAIL %s_bv got %b want %b", name, bound_valid, exp_bv); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_after got done=%b busy=%b want 0/0", name, done, busy); end
    endtask

    task automatic test_basic();
        run4("basic", 4'b1111, {8'sd7, 8'sd12, -8'sd3, 8'sd5});
        run4("inactive_mix", 4'b1010, {-8'sd40, 8'sd50, -8'sd20, 8'sd100});
        run4("all_inactive", 4'b0000, {8'sd4, 8'sd3, 8'sd2, 8'sd1});
        run4("min_active", 4'b0101, {8'sd0, -8'sd128, 8'sd127, -8'sd128});
        run4("equal", 4'b1111, {8'sd9, 8'sd9, 8'sd9, 8'sd9});
    endtask

    task automatic test_toggle();
        logic [6:0] pat = 7'b1011001; // bit i = in_valid in cycle i (1,0,0,1,1,0,1)
        logic signed [W-1:0] vals[4] = '{8'sd3, 8'sd9, -8'sd1, 8'sd4};
        int k = 0;
        int dones = 0;
        pulse_start();
        for (int c = 0; c < 7; c++) begin
            if (done) dones++;
            in_valid = pat[c]; in_activation = 1'b1;
            in_value = pat[c] ? vals[k] : 8'sd127; // junk on idle cycles must be ignored
            if (pat[c]) k++;
            step();
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1 || dones != 0) begin errors++; $display("FAIL toggle_done got %b early=%0d want 1/0", done, dones); end
        checks++; if (bound !== 8'sd9 || bound_valid !== 1'b1) begin errors++; $display("FAIL toggle_bound got %0d/%b want 9/1", bound, bound_valid); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL toggle_single got %b want 0", done); end
        exp_bound = 8'sd9; exp_bv = 1'b1;
    endtask

    task automatic test_abort();
        pulse_start();
        beat(1'b1, 8'sd60);
        beat(1'b1, 8'sd70);
        start = 1'b1; in_valid = 1'b1; in_activation = 1'b1; in_value = 8'sd120;
        step();
        start = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || bound !== exp_bound) begin errors++; $display("FAIL abort_hold got busy=%b bound=%0d want 1/%0d", busy, bound, exp_bound); end
        for (int i = 1; i <= N; i++) begin
            checks++; if (done !== 1'b0 || bound !== exp_bound) begin errors++; $display("FAIL abort_stable got done=%b bound=%0d want 0/%0d", done, bound, exp_bound); end
            beat(1'b1, W'(i));
        end
        checks++; if (done !== 1'b1 || bound !== 8'sd4 || bound_valid !== 1'b1) begin errors++; $display("FAIL abort_result got %b/%0d/%b want 1/4/1", done, bound, bound_valid); end
        step();
        exp_bound = 8'sd4; exp_bv = 1'b1;
    endtask

    task automatic test_start_on_final();
        pulse_start();
        beat(1'b1, -8'sd5); beat(1'b1, -8'sd6); beat(1'b0, 8'sd50);
        start = 1'b1;
        beat(1'b1, -8'sd2);
        start = 1'b0;
        checks++; if (done !== 1'b1 || bound !== -8'sd2) begin errors++; $display("FAIL final_start got %b/%0d want 1/-2", done, bound); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL final_start_idle got busy=%b want 0", busy); end
        exp_bound = -8'sd2; exp_bv = 1'b1;
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 3; i++) beat(1'b1, 8'sd100);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || bound !== exp_bound) begin
            errors++; $display("FAIL idle_valid got busy=%b done=%b rdy=%b bound=%0d want 0/0/0/%0d", busy, done, in_ready, bound, exp_bound);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        beat(1'b1, 8'sd90);
        rst_n = 1'b0;
        #1;
        checks++; if (bound !== -8'sd128 || bound_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid got %0d/%b/%b/%b want -128/0/0/0", bound, bound_valid, busy, done);
        end
        #2 rst_n = 1'b1;
        step();
        run4("post_reset", 4'b0110, {8'sd1, -8'sd7, 8'sd33, 8'sd2});
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            logic signed [W-1:0] m = -8'sd128;
            logic seen = 1'b0;
            int got = 0;
            int cyc = 0;
            pulse_start();
            while (got < N && cyc < 200) begin
                checks++; if (in_ready !== 1'b1 || done !== 1'b0 || bound !== exp_bound) begin
                    errors++; $display("FAIL rand_mid run %0d got rdy=%b done=%b bound=%0d want 1/0/%0d", r, in_ready, done, bound, exp_bound);
                end
                in_valid = 1'($urandom_range(0, 1));
                in_activation = 1'($urandom_range(0, 1));
                in_value = W'($urandom);
                if (in_valid) begin
                    got++;
                    if (in_activation) begin
                        seen = 1'b1;
                        if (in_value > m) m = in_value;
                    end
                end
                step();
                cyc++;
            end
            in_valid = 1'b0;
            if (got < N) begin
                checks++; errors++; $display("FAIL rand_timeout run %0d got %0d beats want %0d", r, got, N);
            end else begin
                exp_bound = m; exp_bv = seen;
                checks++; if (done !== 1'b1 || bound !== m || bound_valid !== seen) begin
                    errors++; $display("FAIL rand_result run %0d got %b/%0d/%b want 1/%0d/%b", r, done, bound, bound_valid, m, seen);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_idle_valid();
        test_abort();
        test_start_on_final();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
